// File: rtl/if_fetch_unit_if.sv
// +--------------------------------------------------------------------+
// | if_fetch_unit_if : fetch unit bus (redirects, imem, IF_ID outputs)   |
// | Optional macro: FETCH_PERF_CNT_EN adds perf_bubble_cnt_out. Rev 1.0  |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface if_fetch_unit_if;
   logic        enable;
   logic        flush_branch;
   logic [31:0] Branch_Target_in;
   logic        flush_jump;
   logic [25:0] Jump_Offset_in;
   logic [31:0] Jump_PC_in;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_gnt_in;
   logic        imem_rvalid_in;
   logic [31:0] imem_rdata_in;
   logic [31:0] Instruction_memory_out;
   logic [31:0] PC_Counter_output;
   logic        fetch_valid_out;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubble_cnt_out;
`endif

   modport master (
      input  enable, flush_branch, Branch_Target_in, flush_jump,
      input  Jump_Offset_in, Jump_PC_in,
      input  imem_gnt_in, imem_rvalid_in, imem_rdata_in,
      output imem_req_out, imem_addr_out,
      output Instruction_memory_out, PC_Counter_output, fetch_valid_out
`ifdef FETCH_PERF_CNT_EN
      , output perf_bubble_cnt_out
`endif
   );

   modport slave (
      output enable, flush_branch, Branch_Target_in, flush_jump,
      output Jump_Offset_in, Jump_PC_in,
      output imem_gnt_in, imem_rvalid_in, imem_rdata_in,
      input  imem_req_out, imem_addr_out,
      input  Instruction_memory_out, PC_Counter_output, fetch_valid_out
`ifdef FETCH_PERF_CNT_EN
      , input perf_bubble_cnt_out
`endif
   );
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// +--------------------------------------------------------------------+
// | if_fetch_unit : single-outstanding instruction fetch with skid slot  |
// | Optional macro: FETCH_PERF_CNT_EN (bubble counter). Rev 1.0          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module if_fetch_unit (
   input  wire logic clk,
   input  wire logic reset_in,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        kill;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic [31:0] instr_q;
   logic [31:0] pc_out_q;
   logic        valid_q;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_plus4;
   logic        slot_free;
   logic        unused_jump_pc;

   assign redirect    = bus.flush_branch | bus.flush_jump;
   // Branch wins when both redirects arrive together.
   assign redirect_pc = bus.flush_branch ? bus.Branch_Target_in
                                         : {bus.Jump_PC_in[31:28], bus.Jump_Offset_in, 2'b00};
   assign pc_plus4    = pc + 32'd4;
   assign slot_free   = ~valid_q | bus.enable;
   assign unused_jump_pc = ^bus.Jump_PC_in[27:0];

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state      <= S_REQ;
         pc         <= 32'd0;
         kill       <= 1'b0;
         skid_instr <= 32'd0;
         skid_pc    <= 32'd0;
         instr_q    <= 32'd0;
         pc_out_q   <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         if (valid_q && bus.enable) begin
            valid_q <= 1'b0;
         end
         if (redirect) begin
            valid_q <= 1'b0;
            pc      <= redirect_pc;
            case (state)
               S_WAIT: begin
                  // A response landing with the redirect retires the old request.
                  if (bus.imem_rvalid_in) begin
                     state <= S_REQ;
                     kill  <= 1'b0;
                  end else begin
                     kill  <= 1'b1;
                  end
               end
               S_REQ: begin
                  if (bus.imem_gnt_in) begin
                     state <= S_WAIT;
                     kill  <= 1'b1;
                  end
               end
               default: begin
                  state <= S_REQ;
                  kill  <= 1'b0;
               end
            endcase
         end else begin
            case (state)
               S_REQ: begin
                  if (bus.imem_gnt_in) begin
                     state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (bus.imem_rvalid_in) begin
                     if (kill) begin
                        kill  <= 1'b0;
                        state <= S_REQ;
                     end else if (slot_free) begin
                        pc       <= pc_plus4;
                        instr_q  <= bus.imem_rdata_in;
                        pc_out_q <= pc_plus4;
                        valid_q  <= 1'b1;
                        state    <= S_REQ;
                     end else begin
                        pc         <= pc_plus4;
                        skid_instr <= bus.imem_rdata_in;
                        skid_pc    <= pc_plus4;
                        state      <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (bus.enable) begin
                     instr_q  <= skid_instr;
                     pc_out_q <= skid_pc;
                     valid_q  <= 1'b1;
                     state    <= S_REQ;
                  end
               end
               default: begin
                  state <= S_REQ;
               end
            endcase
         end
      end
   end

   assign bus.imem_req_out           = (state == S_REQ);
   assign bus.imem_addr_out          = pc;
   assign bus.Instruction_memory_out = instr_q;
   assign bus.PC_Counter_output      = pc_out_q;
   assign bus.fetch_valid_out        = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt;

   // Counts cycles where IF_ID wanted an instruction but none was ready.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         bubble_cnt <= 32'd0;
      end else if (bus.enable && !valid_q && (bubble_cnt != 32'hFFFF_FFFF)) begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end

   assign bus.perf_bubble_cnt_out = bubble_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then random traffic
// compared against a transaction-level queue model.
`timescale 1ns/1ps
`default_nettype none

module tb_if_fetch_unit;

   logic clk = 1'b0;
   logic reset_in;
   always #5 clk = ~clk;

   if_fetch_unit_if bus ();

   if_fetch_unit dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned failed = 0;

   // Model: delivered-but-unconsumed {instr, pc+4}, next fetch PC, outstanding request.
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   logic        m_out;
   logic        m_kill;

   function automatic logic m_req();
      return !m_out && (mq.size() < 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = 32'd0;
      m_addr = 32'd0;
      m_out  = 1'b0;
      m_kill = 1'b0;
   endtask

   task automatic model_edge();
      logic        req;
      logic        consume;
      logic [31:0] tgt;
      req     = m_req();
      consume = (mq.size() > 0) && bus.enable;
      if (bus.flush_branch || bus.flush_jump) begin
         tgt = bus.flush_branch ? bus.Branch_Target_in
                                : {bus.Jump_PC_in[31:28], bus.Jump_Offset_in, 2'b00};
         if (m_out && bus.imem_rvalid_in) m_out = 1'b0;
         else if (m_out) m_kill = 1'b1;
         else if (req && bus.imem_gnt_in) begin
            m_out  = 1'b1;
            m_kill = 1'b1;
         end
         mq.delete();
         m_pc = tgt;
      end else begin
         if (consume) void'(mq.pop_front());
         if (m_out && bus.imem_rvalid_in) begin
            m_out = 1'b0;
            if (!m_kill) begin
               mq.push_back({bus.imem_rdata_in, m_addr + 32'd4});
               m_pc = m_addr + 32'd4;
            end
            m_kill = 1'b0;
         end else if (req && bus.imem_gnt_in) begin
            m_out  = 1'b1;
            m_kill = 1'b0;
            m_addr = m_pc;
         end
      end
   endtask

   task automatic model_check();
      logic [63:0] head;
      chk("valid", 32'(bus.fetch_valid_out), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         head = mq[0];
         chk("instr", bus.Instruction_memory_out, head[63:32]);
         chk("pc_out", bus.PC_Counter_output, head[31:0]);
      end
      chk("req", 32'(bus.imem_req_out), 32'(m_req()));
      if (m_req()) chk("addr", bus.imem_addr_out, m_pc);
   endtask

   task automatic drive(input logic en, input logic fb, input logic [31:0] bt,
                        input logic fj, input logic [25:0] joff, input logic [31:0] jpc,
                        input logic gnt, input logic rv, input logic [31:0] rd);
      bus.enable           = en;
      bus.flush_branch     = fb;
      bus.Branch_Target_in = bt;
      bus.flush_jump       = fj;
      bus.Jump_Offset_in   = joff;
      bus.Jump_PC_in       = jpc;
      bus.imem_gnt_in      = gnt;
      bus.imem_rvalid_in   = rv;
      bus.imem_rdata_in    = rd;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      reset_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset_in = 1'b0;
      model_reset();
   endtask

   initial begin
      logic        r_en, r_fb, r_fj, r_gnt, r_rv;
      logic [31:0] r_bt, r_jpc, r_rd;
      logic [25:0] r_joff;

      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      reset_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_in = 1'b0;
      model_reset();

      // Reset state
      chk("rst_valid", 32'(bus.fetch_valid_out), 32'd0);
      chk("rst_instr", bus.Instruction_memory_out, 32'd0);
      chk("rst_pc_out", bus.PC_Counter_output, 32'd0);
      chk("rst_req", 32'(bus.imem_req_out), 32'd1);
      chk("rst_addr", bus.imem_addr_out, 32'd0);

`ifdef FETCH_PERF_CNT_EN
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
         tick();
      end
      chk("perf_bubbles", bus.perf_bubble_cnt_out, 32'd5);
      do_reset();
`endif

      // First fetch, single-cycle gnt and rvalid
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h22EA_0004);
      tick();
      chk("f1_instr", bus.Instruction_memory_out, 32'h22EA_0004);
      chk("f1_pc_out", bus.PC_Counter_output, 32'h0000_0004);
      chk("f1_addr", bus.imem_addr_out, 32'h0000_0004);

      // Stall: second response goes to the skid slot
      do_reset();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h0800_0101);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h0232_8020);
      tick();
      chk("hold_req", 32'(bus.imem_req_out), 32'd0);
      chk("hold_instr", bus.Instruction_memory_out, 32'h0800_0101);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      chk("hold_req2", 32'(bus.imem_req_out), 32'd0);
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("skid_instr", bus.Instruction_memory_out, 32'h0232_8020);
      chk("skid_pc_out", bus.PC_Counter_output, 32'h0000_0008);
      chk("skid_addr", bus.imem_addr_out, 32'h0000_0008);

      // Jump redirect while waiting: response dropped
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0101, 32'h0000_0008, 1'b0, 1'b0, 32'd0);
      tick();
      chk("jmp_valid", 32'(bus.fetch_valid_out), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      tick();
      chk("jmp_valid2", 32'(bus.fetch_valid_out), 32'd0);
      chk("jmp_addr", bus.imem_addr_out, 32'h0000_0404);

      // Branch beats jump
      drive(1'b0, 1'b1, 32'h0000_0100, 1'b1, 26'h3, 32'hF000_0000, 1'b0, 1'b0, 32'd0);
      tick();
      chk("prio_addr", bus.imem_addr_out, 32'h0000_0100);

      // PC wrap
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      drive(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
      tick();
      chk("wrap_pc_out", bus.PC_Counter_output, 32'h0000_0000);
      chk("wrap_addr", bus.imem_addr_out, 32'h0000_0000);

      // Reset while waiting, stray rvalid afterwards
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      tick();
      do_reset();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0055);
      tick();
      chk("stray_valid", 32'(bus.fetch_valid_out), 32'd0);
      chk("stray_addr", bus.imem_addr_out, 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 500) == 0) begin
            do_reset();
            model_check();
         end
         r_en   = (($urandom % 4) != 0);
         r_fb   = (($urandom % 20) == 0);
         r_fj   = (($urandom % 20) == 0);
         r_bt   = $urandom & 32'hFFFF_FFFC;
         r_joff = 26'($urandom);
         r_jpc  = $urandom;
         r_gnt  = m_req() ? 1'($urandom % 2) : (($urandom % 8) == 0);
         r_rv   = m_out ? 1'($urandom % 2) : (($urandom % 10) == 0);
         r_rd   = $urandom;
         drive(r_en, r_fb, r_bt, r_fj, r_joff, r_jpc, r_gnt, r_rv, r_rd);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
